// File: rtl/vec_lsu.sv
// vec_lsu - vector load/store unit for single 64-bit elements.
//
// Sits between the decode/issue stage and the 64-bit vector register file.
// A load reads two little-endian 32-bit words (addr, addr+4) and writes them
// to the register file as {hi, lo}. A store writes the 64-bit operand as two
// 32-bit beats, low half first. Only one request is in flight at a time.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   req_valid/req_ready   request handshake from issue (ready only when idle)
//   req_is_store          1 = store, 0 = load
//   req_addr              byte address, must be 8-byte aligned
//   req_vd                load destination register index
//   req_sdata             store data (register-file read port 2)
//   mem_req/mem_gnt       memory request handshake
//   mem_we                memory write enable
//   mem_addr              word address of the current beat
//   mem_wdata             store beat data
//   mem_rvalid/mem_rdata  response (read data or write ack) for oldest grant
//   vrf_wen/vrf_vd/vrf_wdata  register-file write port
//   done                  one-cycle completion pulse
//   err                   with done: request was misaligned and aborted
module vec_lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [4:0]        req_vd,
    input  logic [63:0]       req_sdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              vrf_wen,
    output logic [4:0]        vrf_vd,
    output logic [63:0]       vrf_wdata,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        IDLE,
        REQ0,
        RSP0,
        REQ1,
        RSP1,
        FIN
    } state_t;

    state_t            state;
    state_t            stateNext;

    logic              isStore;
    logic [ADDR_W-1:0] addr;
    logic [4:0]        vd;
    logic [63:0]       sdata;
    logic [63:0]       buffer;
    logic              misaligned;
    logic              accept;
    logic              loadOk;

    assign accept = req_valid && (state == IDLE);

    // Request capture, state register and load-data buffering. The request
    // is latched once at accept so later input changes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            isStore    <= 1'b0;
            addr       <= '0;
            vd         <= '0;
            sdata      <= '0;
            buffer     <= '0;
            misaligned <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                isStore    <= req_is_store;
                addr       <= req_addr;
                vd         <= req_vd;
                sdata      <= req_sdata;
                misaligned <= (req_addr[2:0] != 3'b000);
            end
            if (state == RSP0 && mem_rvalid && !isStore) begin
                buffer[31:0] <= mem_rdata;
            end
            if (state == RSP1 && mem_rvalid && !isStore) begin
                buffer[63:32] <= mem_rdata;
            end
        end
    end

    // Next-state logic. Misaligned requests skip memory entirely and go
    // straight to FIN so they still complete with a done/err pulse.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    stateNext = (req_addr[2:0] != 3'b000) ? FIN : REQ0;
                end
            end
            REQ0:    if (mem_gnt)    stateNext = RSP0;
            RSP0:    if (mem_rvalid) stateNext = REQ1;
            REQ1:    if (mem_gnt)    stateNext = RSP1;
            RSP1:    if (mem_rvalid) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // A register write happens only for a successful load to a real
    // destination; v0 is hardwired to zero so its write is dropped.
    assign loadOk = !isStore && !misaligned && (vd != 5'd0);

    // Outputs depend only on the state and captured registers, never on
    // the memory inputs, so there is no combinational path through the unit.
    always_comb begin
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        vrf_wen   = 1'b0;
        vrf_vd    = '0;
        vrf_wdata = '0;
        done      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: req_ready = 1'b1;
            REQ0: begin
                mem_req   = 1'b1;
                mem_we    = isStore;
                mem_addr  = addr;
                mem_wdata = sdata[31:0];
            end
            REQ1: begin
                mem_req   = 1'b1;
                mem_we    = isStore;
                mem_addr  = addr + ADDR_W'(4);
                mem_wdata = sdata[63:32];
            end
            FIN: begin
                done = 1'b1;
                err  = misaligned;
                if (loadOk) begin
                    vrf_wen   = 1'b1;
                    vrf_vd    = vd;
                    vrf_wdata = buffer;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vec_lsu.sv
// tb_vec_lsu - self-checking bench for vec_lsu.
//
// A behavioural memory responder grants requests after a programmable
// number of stall cycles and answers one cycle after the grant. Expected
// memory beats, register writes and done/err pulses are queued when a
// request is accepted and popped as the DUT produces them.
module tb_vec_lsu;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [ADDR_W-1:0] req_addr;
    logic [4:0]        req_vd;
    logic [63:0]       req_sdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;
    logic              vrf_wen;
    logic [4:0]        vrf_vd;
    logic [63:0]       vrf_wdata;
    logic              done;
    logic              err;

    vec_lsu #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_addr     (req_addr),
        .req_vd       (req_vd),
        .req_sdata    (req_sdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .vrf_wen      (vrf_wen),
        .vrf_vd       (vrf_vd),
        .vrf_wdata    (vrf_wdata),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    typedef struct {
        logic [4:0]  vd;
        logic [63:0] data;
    } vrf_t;

    beat_t beatQ[$];
    vrf_t  vrfQ[$];
    logic  doneQ[$];

    logic [31:0] memWords [logic [31:0]];

    int testsRun    = 0;
    int testsFailed = 0;

    int          gntDelay     = 0;
    int          grantCount   = 0;
    bit          blockRsp     = 0;
    bit          injectRvalid = 0;
    int          doneCount    = 0;
    int          wenCount     = 0;
    int          lastDoneCycle = -1;
    int          lastWenCycle  = -1;
    logic [63:0] lastWenData  = '0;
    logic [4:0]  lastWenVd    = '0;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memWords.exists(a)) return memWords[a];
        return {a[15:0], 16'hA5A5};
    endfunction

    // Memory responder: grants after gntDelay stall cycles, answers the
    // cycle after the grant, and checks each beat against the scoreboard.
    initial begin
        beat_t       e;
        int          stallCnt;
        bit          pending;
        logic [31:0] pendAddr;
        bit          pendRead;
        stallCnt = 0;
        pending  = 0;
        pendAddr = '0;
        pendRead = 0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (!rst_n) begin
                pending  = 0;
                stallCnt = 0;
            end else begin
                if (injectRvalid) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = 32'hFFFF_FFFF;
                end else if (pending && !blockRsp) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = pendRead ? memRead(pendAddr) : 32'h0;
                    pending    = 0;
                end
                if (!mem_req && stallCnt != 0) begin
                    checkOutput("req_dropped_in_stall", 0, 1);
                    stallCnt = 0;
                end
                if (mem_req) begin
                    if (beatQ.size() == 0) begin
                        checkOutput("unexpected_memreq", 1, 0);
                        mem_gnt = 1'b1;
                        pending = 1;
                        pendAddr = mem_addr;
                        pendRead = !mem_we;
                    end else if (stallCnt < gntDelay) begin
                        stallCnt++;
                        checkOutput("stall_addr", mem_addr, beatQ[0].addr);
                        checkOutput("stall_we", mem_we, beatQ[0].we);
                        if (beatQ[0].we) checkOutput("stall_wdata", mem_wdata, beatQ[0].wdata);
                    end else begin
                        e = beatQ.pop_front();
                        checkOutput("beat_we", mem_we, e.we);
                        checkOutput("beat_addr", mem_addr, e.addr);
                        if (e.we) checkOutput("beat_wdata", mem_wdata, e.wdata);
                        mem_gnt    = 1'b1;
                        pending    = 1;
                        pendAddr   = mem_addr;
                        pendRead   = !mem_we;
                        stallCnt   = 0;
                        grantCount++;
                    end
                end
            end
        end
    end

    // Completion monitor: every done and every register write must match
    // an entry queued when the request was accepted.
    initial begin
        vrf_t w;
        forever begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                lastDoneCycle = cyc;
                if (doneQ.size() == 0) checkOutput("done_unexpected", 1, 0);
                else checkOutput("done_err", err, doneQ.pop_front());
            end
            if (vrf_wen) begin
                wenCount++;
                lastWenCycle = cyc;
                lastWenData  = vrf_wdata;
                lastWenVd    = vrf_vd;
                if (vrfQ.size() == 0) begin
                    checkOutput("vrf_unexpected", 1, 0);
                end else begin
                    w = vrfQ.pop_front();
                    checkOutput("vrf_vd", vrf_vd, w.vd);
                    checkOutput("vrf_wdata", vrf_wdata, w.data);
                end
            end
        end
    end

    // Drive one request and wait for it to be accepted; expectations are
    // queued at the accept cycle. Inputs are scrambled afterwards.
    task automatic applyStimulus(input logic st, input logic [31:0] a, input logic [4:0] vd,
                                 input logic [63:0] sd, input bit keepValid, output int tAcc);
        int   n;
        vrf_t w;
        n = 0;
        req_valid    = 1'b1;
        req_is_store = st;
        req_addr     = a;
        req_vd       = vd;
        req_sdata    = sd;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            checkOutput("accept_timeout", 0, 1);
            tAcc = -1;
        end else begin
            tAcc = cyc;
            if (a[2:0] != 3'b000) begin
                doneQ.push_back(1'b1);
            end else begin
                beatQ.push_back('{we: st, addr: a, wdata: sd[31:0]});
                beatQ.push_back('{we: st, addr: a + 32'd4, wdata: sd[63:32]});
                doneQ.push_back(1'b0);
                if (!st && vd != 5'd0) begin
                    w.vd   = vd;
                    w.data = {memRead(a + 32'd4), memRead(a)};
                    vrfQ.push_back(w);
                end
            end
        end
        @(negedge clk);
        #1;
        req_valid    = keepValid;
        req_is_store = ~st;
        req_addr     = 32'h0000_0013;
        req_vd       = 5'd7;
        req_sdata    = 64'h5555_AAAA_5555_AAAA;
    endtask

    task automatic waitDone(input int startCount, input int budget);
        int n;
        n = 0;
        while (doneCount == startCount && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (doneCount == startCount) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic waitCycle(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready, 1);
        checkOutput({tag, "_mem_req"}, mem_req, 0);
        checkOutput({tag, "_mem_we"}, mem_we, 0);
        checkOutput({tag, "_mem_addr"}, mem_addr, 0);
        checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
        checkOutput({tag, "_vrf_wen"}, vrf_wen, 0);
        checkOutput({tag, "_vrf_vd"}, vrf_vd, 0);
        checkOutput({tag, "_vrf_wdata"}, vrf_wdata, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_err"}, err, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int tA;
        int tB;
        int d0;
        int w0;
        int g0;
        int n;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_addr     = '0;
        req_vd       = '0;
        req_sdata    = '0;

        memWords[32'h100] = 32'h89AB_CDEF;
        memWords[32'h104] = 32'h0123_4567;
        memWords[32'h000] = 32'h1111_2222;
        memWords[32'h004] = 32'h3333_4444;
        memWords[32'h200] = 32'hAAAA_0001;
        memWords[32'h204] = 32'hBBBB_0002;
        memWords[32'h208] = 32'hCCCC_0003;
        memWords[32'h20C] = 32'hDDDD_0004;
        memWords[32'h040] = 32'h4040_4040;
        memWords[32'h044] = 32'h4444_4444;

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        checkIdleOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        // Zero-wait load
        d0 = doneCount;
        applyStimulus(1'b0, 32'h100, 5'd3, 64'h0, 1'b0, tA);
        waitDone(d0, 50);
        checkOutput("load_done_latency", lastDoneCycle - tA, 5);
        checkOutput("load_wen_latency", lastWenCycle - tA, 5);
        checkOutput("load_vd", lastWenVd, 5'd3);
        checkOutput("load_data", lastWenData, 64'h0123_4567_89AB_CDEF);
        waitCycle(tA + 6);
        checkOutput("load_ready_t6", req_ready, 1);

        // Store with three stall cycles per beat
        gntDelay = 3;
        d0 = doneCount;
        w0 = wenCount;
        applyStimulus(1'b1, 32'h20, 5'd9, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, tA);
        waitDone(d0, 100);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("store_done_once", doneCount - d0, 1);
        checkOutput("store_no_wen", wenCount - w0, 0);
        checkOutput("store_beats_consumed", beatQ.size(), 0);

        // Stalled load
        gntDelay = 2;
        d0 = doneCount;
        applyStimulus(1'b0, 32'h208, 5'd31, 64'h0, 1'b0, tA);
        waitDone(d0, 100);
        checkOutput("stall_load_vd", lastWenVd, 5'd31);
        gntDelay = 0;

        // Misaligned
        d0 = doneCount;
        g0 = grantCount;
        @(negedge clk);
        #1;
        applyStimulus(1'b0, 32'h104, 5'd4, 64'h0, 1'b0, tA);
        waitDone(d0, 20);
        checkOutput("misaligned_done_latency", lastDoneCycle - tA, 1);
        waitCycle(tA + 2);
        checkOutput("misaligned_ready_t2", req_ready, 1);
        checkOutput("misaligned_no_mem", grantCount - g0, 0);

        // Load to v0
        d0 = doneCount;
        w0 = wenCount;
        g0 = grantCount;
        applyStimulus(1'b0, 32'h0, 5'd0, 64'h0, 1'b0, tA);
        waitDone(d0, 50);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("v0_two_reads", grantCount - g0, 2);
        checkOutput("v0_done", doneCount - d0, 1);
        checkOutput("v0_no_wen", wenCount - w0, 0);

        // Back-to-back loads with req_valid held high
        d0 = doneCount;
        w0 = wenCount;
        applyStimulus(1'b0, 32'h200, 5'd5, 64'h0, 1'b1, tA);
        applyStimulus(1'b0, 32'h208, 5'd6, 64'h0, 1'b0, tB);
        checkOutput("b2b_second_accept", tB - tA, 6);
        waitDone(d0 + 1, 50);
        checkOutput("b2b_two_writes", wenCount - w0, 2);
        checkOutput("b2b_last_vd", lastWenVd, 5'd6);
        checkOutput("b2b_last_data", lastWenData, 64'hDDDD_0004_CCCC_0003);

        // Reset while waiting for the second read response
        d0 = doneCount;
        w0 = wenCount;
        g0 = grantCount;
        applyStimulus(1'b0, 32'h40, 5'd8, 64'h0, 1'b0, tA);
        n = 0;
        while (grantCount < g0 + 2 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        checkOutput("rst_reached_rsp1", grantCount - g0, 2);
        blockRsp = 1;
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkIdleOutputs("midreset");
        repeat (2) @(negedge clk);
        #1;
        beatQ.delete();
        vrfQ.delete();
        doneQ.delete();
        blockRsp = 0;
        rst_n = 1'b1;
        injectRvalid = 1;
        repeat (2) @(negedge clk);
        #1;
        injectRvalid = 0;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("rst_no_done", doneCount - d0, 0);
        checkOutput("rst_no_wen", wenCount - w0, 0);
        checkIdleOutputs("postreset");

        checkOutput("left_beats", beatQ.size(), 0);
        checkOutput("left_vrf", vrfQ.size(), 0);
        checkOutput("left_done", doneQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/vec_lsu.md
Name: vec_lsu

Overview:
- Vector load/store unit between the decode/issue stage and the 64-bit vector register file.
- Vector loads (VLE64-style, one 64-bit element) fetch two little-endian 32-bit words from data memory and drive the register-file write port (wen/vd/wdata).
- Vector stores take the register-file read data (vs2 operand) and write it to memory as two 32-bit beats.
- One request in flight; a multi-cycle FSM handles memory handshakes.

Parameters:
- ADDR_W, 32, byte-address width of req_addr and mem_addr.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  issue stage presents a request.
- req_ready  output  1  unit can accept a request; high only in IDLE.
- req_is_store  input  1  1 = store, 0 = load.
- req_addr  input  ADDR_W  byte address; must be 8-byte aligned.
- req_vd  input  5  load destination register index.
- req_sdata  input  64  store data, from register-file read port 2.
- mem_req  output  1  memory request valid.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  word address (byte address, bits [1:0] = 0).
- mem_wdata  output  32  store beat data.
- mem_gnt  input  1  memory accepted the request this cycle.
- mem_rvalid  input  1  response for the oldest granted request (read data or write ack).
- mem_rdata  input  32  read data, valid with mem_rvalid.
- vrf_wen  output  1  register-file write enable.
- vrf_vd  output  5  register-file write index.
- vrf_wdata  output  64  register-file write data.
- done  output  1  one-cycle pulse when the request completes.
- err  output  1  valid with done; 1 = misaligned request, aborted.

Behaviour:
- Reset: async on rst_n low. State = IDLE. req_ready = 1; mem_req, mem_we, vrf_wen, done, err = 0; mem_addr, mem_wdata, vrf_vd, vrf_wdata = 0. Reset mid-operation abandons the request: no register write and no done. Any later mem_rvalid is ignored.
- Accept: when req_valid && req_ready, capture is_store, addr, vd and sdata into internal registers. Input changes after that have no effect.
- States: IDLE, REQ0, RSP0, REQ1, RSP1, FIN.
- IDLE -> FIN on accept if addr[2:0] != 0 (err = 1, no memory access); otherwise IDLE -> REQ0.
- REQ0: mem_req = 1, mem_addr = addr, mem_we = is_store, mem_wdata = sdata[31:0]. All held stable until mem_gnt. On mem_gnt -> RSP0.
- RSP0: mem_req = 0; wait for mem_rvalid. On a load, capture mem_rdata into buffer[31:0]. Then -> REQ1.
- REQ1: as REQ0 with mem_addr = addr + 4 and mem_wdata = sdata[63:32]. On mem_gnt -> RSP1.
- RSP1: on mem_rvalid (load: capture into buffer[63:32]) -> FIN.
- FIN: lasts one cycle.
  - done = 1.
  - For a load with no error: vrf_wen = 1, vrf_vd = vd, vrf_wdata = {hi word, lo word} registered.
  - vrf_wen is suppressed when vd == 0 (v0 is hardwired zero).
  - Then -> IDLE.
- mem_rvalid outside RSP0/RSP1 is ignored. mem_rvalid may arrive no earlier than the cycle after mem_gnt.
- All outputs are registered or decoded from state only. There are no combinational paths from mem_* inputs to outputs.
- Minimum latency with zero-wait memory: accept at cycle T; REQ0 at T+1; RSP0 at T+2; REQ1 at T+3; RSP1 at T+4; FIN (done, vrf_wen) at T+5; req_ready at T+6.
- Misaligned request: done with err = 1 at T+1, req_ready at T+2.
- Wait states: unbounded stalls on mem_gnt or mem_rvalid are legal. The unit holds state and outputs without any timeout.

Test Plan:
- Load, zero-wait: addr 0x100, vd = 3; mem returns 0x89ABCDEF at 0x100 and 0x01234567 at 0x104 -> vrf_wen at T+5, vrf_vd = 3, vrf_wdata = 0x0123456789ABCDEF, done = 1, err = 0.
- Store with stalls: addr 0x20, sdata = 0xDEADBEEF_CAFEF00D, mem_gnt delayed 3 cycles per beat -> beat 0 {we = 1, addr 0x20, wdata 0xCAFEF00D} then beat 1 {addr 0x24, wdata 0xDEADBEEF}; mem_req and mem_addr stable throughout each stall; vrf_wen never asserts; done pulses once.
- Misaligned: addr 0x104 -> mem_req never asserts; done = 1 and err = 1 at T+1; req_ready high at T+2.
- Load to v0: addr 0x0, vd = 0 -> two memory reads occur; done = 1; vrf_wen stays 0.
- Reset mid-load: rst_n low while in RSP1, then mem_rvalid pulses after release -> all outputs 0, no vrf_wen, no done; req_ready = 1 after release.
- Back-to-back: req_valid held high with two loads -> second request accepted only in the cycle after FIN (req_ready = 0 while busy); both writes land with the correct vd and data.
